data_cache_responder: RTL and testbench

- Memory-side responder for the controller's data-memory handshake (`MemRead`/`MemWrite`/`busy`).
- Direct-mapped, write-through, no-write-allocate cache in front of an internal slow backing memory of 2**NBITS bytes.
- Drives `busy` combinationally so the controller's PC stall logic sees it in the same cycle as the request.
- Sits between the datapath's ALU address/`RS2` data path and the rest of the design. It exports hit/miss counters for the debug ("zoi") view.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_array.sv | 42 ++++
 rtl/data_cache_responder.sv | 116 +++++++++++
 tb/tb_data_cache_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache responder.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} dc_state_t;

  localparam int NBITS_DEF        = 8;
  localparam int NLINES_DEF       = 4;
  localparam int MISS_LATENCY_DEF = 3;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, one synchronous write port.
module dcache_array #(
  parameter int NBITS  = 8,
  parameter int NLINES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] addr,
  output logic             hit,
  output logic [NBITS-1:0] line_data,
  input  logic             we,
  input  logic [NBITS-1:0] waddr,
  input  logic [NBITS-1:0] wdata
);
  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = NBITS - IDXW;

  logic [NLINES-1:0] valid;
  logic [TAGW-1:0]   tags  [NLINES];
  logic [NBITS-1:0]  lines [NLINES];
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   widx;

  assign idx       = addr[IDXW-1:0];
  assign widx      = waddr[IDXW-1:0];
  assign hit       = valid[idx] && (tags[idx] == addr[NBITS-1:IDXW]);
  assign line_data = lines[idx];

  always_ff @(posedge clock) begin
    if (!reset)  valid       <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  // Tag and data are not cleared; a reset edge still blocks any install.
  always_ff @(posedge clock) begin
    if (reset && we) begin
      tags[widx]  <= waddr[NBITS-1:IDXW];
      lines[widx] <= wdata;
    end
  end

endmodule

// File: rtl/data_cache_responder.sv
// Write-through, no-write-allocate data cache with a slow internal backing memory.
module data_cache_responder
  import dcache_pkg::*;
#(
  parameter int NBITS        = NBITS_DEF,
  parameter int NLINES       = NLINES_DEF,
  parameter int MISS_LATENCY = MISS_LATENCY_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic [7:0]       hit_count,
  output logic [7:0]       miss_count
);
  localparam int CNTW = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

  dc_state_t        state, next_state;
  logic [CNTW-1:0]  counter;
  logic [NBITS-1:0] addr_q;
  logic [NBITS-1:0] wdata_q;
  logic [NBITS-1:0] mem [2**NBITS];

  logic             hit;
  logic [NBITS-1:0] line_data;
  logic [NBITS-1:0] lookup_addr;
  logic             rd_hit, rd_miss, fill_done, write_done;
  logic             arr_we;
  logic [NBITS-1:0] arr_wdata;

  // In IDLE the live request is looked up; afterwards the latched address is.
  assign lookup_addr = (state == IDLE) ? addr : addr_q;

  dcache_array #(.NBITS(NBITS), .NLINES(NLINES)) u_array (
    .clock     (clock),
    .reset     (reset),
    .addr      (lookup_addr),
    .hit       (hit),
    .line_data (line_data),
    .we        (arr_we),
    .waddr     (addr_q),
    .wdata     (arr_wdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (MemWrite) next_state = WRITE;
               else if (rd_miss) next_state = FILL;
      FILL:    if (counter == '0) next_state = IDLE;
      WRITE:   if (counter == '0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_hit     = (state == IDLE) && !MemWrite && MemRead && hit;
    rd_miss    = (state == IDLE) && !MemWrite && MemRead && !hit;
    fill_done  = (state == FILL) && (counter == '0);
    write_done = (state == WRITE) && (counter == '0);
    arr_we     = fill_done || (write_done && hit);
    arr_wdata  = fill_done ? mem[addr_q] : wdata_q;
    busy       = 1'b0;
    unique case (state)
      IDLE:        busy = MemWrite || rd_miss;
      FILL, WRITE: busy = 1'b1;
      ACK:         busy = 1'b0;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)
      counter <= '0;
    else if ((state == IDLE) && (MemWrite || rd_miss))
      counter <= CNTW'(MISS_LATENCY - 1);
    else if (((state == FILL) || (state == WRITE)) && (counter != '0))
      counter <= counter - 1'b1;
  end

  // Request is captured when leaving IDLE so a withdrawn request still commits.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && (MemWrite || rd_miss)) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && write_done) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit)         rdata <= line_data;
      else if (fill_done) rdata <= mem[addr_q];
      if (rd_hit)  hit_count  <= sat_inc(hit_count);
      if (rd_miss) miss_count <= sat_inc(miss_count);
    end
  end

endmodule

// File: tb/tb_data_cache_responder.sv
// Scoreboard bench: driver pushes model expectations, monitor pops on each completion.
module tb_data_cache_responder;
  localparam int NL = 4;
  localparam int ML = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic       MemRead = 1'b0, MemWrite = 1'b0;
  logic [7:0] rdata, hit_count, miss_count;
  logic       busy;

  data_cache_responder dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .rdata(rdata), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        known;
    logic [7:0]  rdata;
    logic [31:0] busy;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   busy_run = 0;

  // Reference model: memory contents and which lines hold which tags.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  bit         m_valid [NL];
  int         m_tag [NL];
  int         m_hits, m_misses;
  logic [7:0] m_last;
  bit         m_last_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    m_hits = 0; m_misses = 0; m_last = 8'h00; m_last_known = 1;
  endfunction

  function automatic exp_t model_read(input int a);
    exp_t e;
    int idx = a % NL;
    int tag = a / NL;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      m_hits++;
      e.busy = 0;
    end else begin
      m_misses++;
      m_valid[idx] = 1; m_tag[idx] = tag;
      m_hits++;
      e.busy = ML + 1;
    end
    m_last = m_mem[a]; m_last_known = m_known[a];
    e.known = m_last_known; e.rdata = m_last;
    e.hits = sat(m_hits); e.misses = sat(m_misses);
    return e;
  endfunction

  function automatic exp_t model_write(input int a, input logic [7:0] d);
    exp_t e;
    m_mem[a] = d; m_known[a] = 1;
    e.busy = ML + 1;
    e.known = m_last_known; e.rdata = m_last;
    e.hits = sat(m_hits); e.misses = sat(m_misses);
    return e;
  endfunction

  // Monitor: counts busy cycles of the held request and checks each completion.
  always @(negedge clock) begin
    exp_t e;
    int   got;
    if (!reset || !(MemRead || MemWrite)) busy_run = 0;
    else if (busy) busy_run++;
    else begin
      got = busy_run; busy_run = 0;
      @(posedge clock); #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_completion: got one, expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("busy_cycles", got, e.busy);
        if (e.known) check("rdata", {24'h0, rdata}, {24'h0, e.rdata});
        check("hit_count", {24'h0, hit_count}, e.hits);
        check("miss_count", {24'h0, miss_count}, e.misses);
      end
    end
  end

  task automatic op(input bit wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    if (wr) exp_q.push_back(model_write(a, d));
    else    exp_q.push_back(model_read(a));
    addr = a; wdata = d; MemWrite = wr; MemRead = !wr;
    forever begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected release", n);
        break;
      end
    end
    @(posedge clock); #1;
    MemRead = 0; MemWrite = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t dummy;
    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; m_known[i] = 0; end
    m_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_rdata", {24'h0, rdata}, 32'h00);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_hits", {24'h0, hit_count}, 32'h0);
    check("reset_misses", {24'h0, miss_count}, 32'h0);
    reset = 1;
    idle(1);

    // Directed sequence
    op(1, 8'h10, 8'hA5);
    op(0, 8'h10, 8'h00);
    op(0, 8'h10, 8'h00);
    op(0, 8'h14, 8'h00);
    op(0, 8'h10, 8'h00);
    op(1, 8'h10, 8'h3C);
    op(0, 8'h10, 8'h00);

    // Write withdrawn after one cycle still commits the latched address/data
    addr = 8'h30; wdata = 8'h77; MemWrite = 1;
    dummy = model_write(8'h30, 8'h77);
    idle(1);
    MemWrite = 0; addr = 8'h31; wdata = 8'h00;
    idle(6);
    op(0, 8'h30, 8'h00);

    // Read withdrawn during FILL still installs the line (no replay hit)
    op(1, 8'h44, 8'h5A);
    addr = 8'h44; MemRead = 1;
    dummy = model_read(8'h44);
    m_hits--;
    idle(1);
    MemRead = 0; addr = 8'h00;
    idle(6);
    op(0, 8'h44, 8'h00);

    // Reset during the second FILL cycle aborts the fill
    addr = 8'h20; MemRead = 1;
    idle(2);
    reset = 0; MemRead = 0;
    idle(1);
    reset = 1;
    m_reset();
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_rdata", {24'h0, rdata}, 32'h00);
    check("abort_hits", {24'h0, hit_count}, 32'h0);
    check("abort_misses", {24'h0, miss_count}, 32'h0);
    idle(1);
    op(0, 8'h20, 8'h00);
    op(0, 8'h20, 8'h00);

    // Randomized traffic over a small address pool (drives counters into saturation)
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = 8'h80 | 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 3) op(1, a, 8'($urandom));
      else                          op(0, a, 8'($urandom));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
